// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, CTRL fields,
// FSM state encoding and widths.
package irq_ctrl_pkg;

    localparam logic [1:0] ADDR_MASK = 2'd0;
    localparam logic [1:0] ADDR_PEND = 2'd1;
    localparam logic [1:0] ADDR_CUR  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_LVL      = 1;
    localparam int CUR_VALID_BIT = 31;
    localparam int ID_W          = 3;
    localparam int CPU_IRQ_W     = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        GAP     = 2'd2
    } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set index of req wins.
module irq_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 6
) (
    input  logic [NUM_SRC-1:0] req,
    output logic [ID_W-1:0]    idx,
    output logic               vld
);

    always_comb begin
        idx = '0;
        vld = |req;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches/masks source requests and presents one at a time
// to the CPU. Optional IRQ_SYNC_EN adds a 2-flop synchronizer on src_irq.
//   state   | meaning
//   IDLE    | waiting for an eligible pending source
//   PRESENT | intq shows cur_id until ack, mask/enable drop or level release
//   GAP     | one cycle of intq=0 before the next selection
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int          NUM_SRC  = 6,
    parameter logic [5:0]  RST_MASK = 6'b000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:2]         addr,
    input  logic               we,
    input  logic [31:0]        din,
    output logic [31:0]        dout,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic [5:0]         intq
);

    logic [NUM_SRC-1:0] src_in, src_q, mask_q, pend_q, pend_n;
    logic [NUM_SRC-1:0] set_vec, clr_vec, elig, cur_bit;
    logic               en_q, lvl_q, ack, win_vld;
    logic [ID_W-1:0]    cur_id_q, cur_id_n, win_id;
    logic [5:0]         intq_q, intq_n;
    state_t             state_q, state_n;
    logic               wr_mask, wr_pend, wr_cur, wr_ctrl;
    logic               unused_din;

    assign unused_din = ^din[31:NUM_SRC];

`ifdef IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_irq;
            sync2_q <= sync1_q;
        end
    end
    assign src_in = sync2_q;
`else
    assign src_in = src_irq;
`endif

    assign wr_mask = we && (addr == ADDR_MASK);
    assign wr_pend = we && (addr == ADDR_PEND);
    assign wr_cur  = we && (addr == ADDR_CUR);
    assign wr_ctrl = we && (addr == ADDR_CTRL);

    assign cur_bit = NUM_SRC'(1) << cur_id_q;
    assign elig    = en_q ? (pend_q & mask_q) : '0;
    assign ack     = wr_cur || (wr_pend && |(din[NUM_SRC-1:0] & cur_bit));

    // Set has priority over W1C; level mode simply tracks the source.
    always_comb begin
        set_vec = lvl_q ? src_in : (src_in & ~src_q);
        clr_vec = '0;
        if (wr_pend) clr_vec = din[NUM_SRC-1:0];
        if (wr_cur && state_q == PRESENT) clr_vec = clr_vec | cur_bit;
        pend_n = lvl_q ? set_vec : (set_vec | (pend_q & ~clr_vec));
    end

    irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
        .req (elig),
        .idx (win_id),
        .vld (win_vld)
    );

    always_comb begin
        state_n  = state_q;
        cur_id_n = cur_id_q;
        intq_n   = '0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_n  = PRESENT;
                    cur_id_n = win_id;
                end
            end
            PRESENT: begin
                if (ack || !(|(mask_q & cur_bit)) || !en_q ||
                    (lvl_q && !(|(pend_q & cur_bit)))) begin
                    state_n = GAP;
                end else begin
                    intq_n = CPU_IRQ_W'(cur_bit);
                end
            end
            GAP:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q   <= RST_MASK[NUM_SRC-1:0];
            pend_q   <= '0;
            src_q    <= '0;
            en_q     <= 1'b0;
            lvl_q    <= 1'b0;
            state_q  <= IDLE;
            cur_id_q <= '0;
            intq_q   <= '0;
        end else begin
            src_q    <= src_in;
            pend_q   <= pend_n;
            state_q  <= state_n;
            cur_id_q <= cur_id_n;
            intq_q   <= intq_n;
            if (wr_mask) mask_q <= din[NUM_SRC-1:0];
            if (wr_ctrl) begin
                en_q  <= din[CTRL_EN];
                lvl_q <= din[CTRL_LVL];
            end
        end
    end

    assign intq = intq_q;

    always_comb begin
        dout = '0;
        case (addr)
            ADDR_MASK: dout = 32'(mask_q);
            ADDR_PEND: dout = 32'(pend_q);
            ADDR_CUR: begin
                dout[CUR_VALID_BIT] = (state_q == PRESENT);
                dout[4:0]           = 5'(cur_id_q);
            end
            ADDR_CTRL: dout = 32'({lvl_q, en_q});
            default:   dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized
// pending-capture and priority-order checks against an arithmetic model.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic        we = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] dout;
    logic [5:0]  src_irq = '0;
    logic [5:0]  intq;

    int checks = 0;
    int errors = 0;

    irq_ctrl #(.NUM_SRC(6), .RST_MASK(6'b000000)) dut (
        .clk     (clk),
        .reset   (reset),
        .addr    (addr),
        .we      (we),
        .din     (din),
        .dout    (dout),
        .src_irq (src_irq),
        .intq    (intq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = a; din = d; we = 1'b1;
        tick();
        we = 1'b0; din = '0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    task automatic wait_intq(input int max, output int n, output logic ok);
        n = 0;
        while (intq === 6'd0 && n < max) begin
            tick();
            n++;
        end
        ok = (intq !== 6'd0);
    endtask

    task automatic test_reset();
        logic [31:0] r;
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), r);
            checks++;
            if (r !== 32'd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %h expected %h", a, r, 32'd0);
            end
        end
        checks++;
        if (intq !== 6'd0) begin
            errors++;
            $display("FAIL reset_intq: got %h expected 00", intq);
        end
    endtask

    task automatic test_latency();
        logic [31:0] r;
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h3);
        src_irq = 6'h02;
        tick();
        src_irq = 6'h00;
        repeat (SYNC_LAT) tick();
        rd(2'd1, r);
        checks++;
        if (r !== 32'h2) begin errors++; $display("FAIL lat_pend: got %h expected 2", r); end
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL lat_k0: got %h expected 00", intq); end
        tick();
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL lat_k1: got %h expected 00", intq); end
        tick();
        checks++;
        if (intq !== 6'h02) begin errors++; $display("FAIL lat_k2: got %h expected 02", intq); end
        rd(2'd2, r);
        checks++;
        if (r !== 32'h8000_0001) begin errors++; $display("FAIL lat_cur: got %h expected 80000001", r); end
        wr(2'd1, 32'h2);
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL ack_gap: got %h expected 00", intq); end
        repeat (4) tick();
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL ack_stay: got %h expected 00", intq); end
        rd(2'd2, r);
        checks++;
        if (r !== 32'h0000_0001) begin errors++; $display("FAIL ack_cur: got %h expected 00000001", r); end
    endtask

    task automatic test_priority();
        logic [31:0] r;
        int n;
        logic ok;
        wr(2'd0, 32'h7);
        src_irq = 6'h05;
        tick();
        src_irq = 6'h00;
        wait_intq(8 + SYNC_LAT, n, ok);
        checks++;
        if (!ok || intq !== 6'h01) begin errors++; $display("FAIL prio_first: got %h expected 01", intq); end
        rd(2'd2, r);
        checks++;
        if (r !== 32'h8000_0000) begin errors++; $display("FAIL prio_cur0: got %h expected 80000000", r); end
        wr(2'd2, 32'd0);
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL prio_gap: got %h expected 00", intq); end
        wait_intq(6, n, ok);
        checks++;
        if (!ok || intq !== 6'h04) begin errors++; $display("FAIL prio_second: got %h expected 04", intq); end
        rd(2'd1, r);
        checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL prio_pend: got %h expected 4", r); end
    endtask

    task automatic test_mask_drop();
        logic [31:0] r;
        int n;
        logic ok;
        wr(2'd0, 32'h3);
        tick();
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL mask_drop_intq: got %h expected 00", intq); end
        rd(2'd1, r);
        checks++;
        if (r !== 32'h4) begin errors++; $display("FAIL mask_drop_pend: got %h expected 4", r); end
        repeat (3) tick();
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL mask_drop_hold: got %h expected 00", intq); end
        wr(2'd0, 32'h7);
        wait_intq(6, n, ok);
        checks++;
        if (!ok || intq !== 6'h04) begin errors++; $display("FAIL mask_reen: got %h expected 04", intq); end
        wr(2'd1, 32'h4);
        tick();
        rd(2'd1, r);
        checks++;
        if (r !== 32'h0 || intq !== 6'd0) begin
            errors++; $display("FAIL mask_clear: got pend %h intq %h expected 0 and 00", r, intq);
        end
    endtask

    task automatic test_w1c_set();
        logic [31:0] r;
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd0);
        src_irq = 6'h08;
        repeat (SYNC_LAT) tick();
        wr(2'd1, 32'h8);
        rd(2'd1, r);
        checks++;
        if (r !== 32'h8) begin errors++; $display("FAIL set_wins: got %h expected 8", r); end
        wr(2'd1, 32'h8);
        rd(2'd1, r);
        checks++;
        if (r !== 32'h0) begin errors++; $display("FAIL w1c_plain: got %h expected 0", r); end
        src_irq = 6'h00;
        repeat (SYNC_LAT + 1) tick();
    endtask

    task automatic test_level();
        logic [31:0] r;
        int n;
        logic ok;
        wr(2'd3, 32'd3);
        wr(2'd0, 32'h3F);
        src_irq = 6'h10;
        wait_intq(10, n, ok);
        checks++;
        if (!ok || intq !== 6'h10 || n != 3 + SYNC_LAT) begin
            errors++;
            $display("FAIL lvl_latency: got intq %h after %0d cycles expected 10 after %0d", intq, n, 3 + SYNC_LAT);
        end
        rd(2'd1, r);
        checks++;
        if (r !== 32'h10) begin errors++; $display("FAIL lvl_pend: got %h expected 10", r); end
        src_irq = 6'h00;
        n = 0;
        while (intq !== 6'd0 && n < 6) begin tick(); n++; end
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL lvl_release: got %h expected 00", intq); end
        repeat (3) tick();
        rd(2'd1, r);
        checks++;
        if (r !== 32'h0 || intq !== 6'd0) begin
            errors++; $display("FAIL lvl_idle: got pend %h intq %h expected 0 and 00", r, intq);
        end
        rd(2'd2, r);
        checks++;
        if (r !== 32'h0000_0004) begin errors++; $display("FAIL lvl_cur: got %h expected 00000004", r); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] r;
        int n;
        logic ok;
        src_irq = 6'h10;
        wait_intq(10, n, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL midrst_setup: got %h expected 10", intq); end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (intq !== 6'd0) begin errors++; $display("FAIL midrst_intq: got %h expected 00", intq); end
        rd(2'd3, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL midrst_ctrl: got %h expected 0", r); end
        rd(2'd0, r);
        checks++;
        if (r !== 32'd0) begin errors++; $display("FAIL midrst_mask: got %h expected 0", r); end
        src_irq = 6'h00;
        tick();
        reset = 1'b1;
        repeat (SYNC_LAT + 2) tick();
    endtask

    task automatic test_random_pending();
        logic [31:0] r;
        logic [5:0]  exp_pend, prev, s;
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd0);
        wr(2'd1, 32'h3F);
        for (int round = 0; round < 4; round++) begin
            exp_pend = '0;
            prev = src_irq;
            for (int c = 0; c < 20; c++) begin
                s = 6'($urandom & 32'h3F);
                src_irq = s;
                exp_pend = exp_pend | (s & ~prev);
                prev = s;
                tick();
            end
            src_irq = 6'h00;
            repeat (SYNC_LAT + 1) tick();
            rd(2'd1, r);
            checks++;
            if (r !== 32'(exp_pend)) begin
                errors++; $display("FAIL rand_pend%0d: got %h expected %h", round, r, exp_pend);
            end
            wr(2'd1, 32'h3F);
        end
    endtask

    task automatic test_random_priority();
        logic [31:0] r;
        logic [5:0]  v, m, e, low;
        int n, id;
        logic ok;
        for (int t = 0; t < 6; t++) begin
            v = 6'($urandom_range(1, 63));
            m = 6'($urandom_range(1, 63));
            if ((v & m) == 6'd0) m = m | v;
            wr(2'd3, 32'd0);
            src_irq = v;
            tick();
            src_irq = 6'h00;
            repeat (SYNC_LAT + 1) tick();
            wr(2'd0, 32'(m));
            wr(2'd3, 32'd1);
            e = v & m;
            while (e != 6'd0) begin
                low = e & (~e + 6'd1);
                id = 0;
                for (int b = 5; b >= 0; b--) if (low[b]) id = b;
                wait_intq(8, n, ok);
                checks++;
                if (!ok || intq !== low) begin
                    errors++; $display("FAIL rand_prio_t%0d: got %h expected %h", t, intq, low);
                end
                rd(2'd2, r);
                checks++;
                if (r !== (32'h8000_0000 | 32'(id))) begin
                    errors++; $display("FAIL rand_cur_t%0d: got %h expected %h", t, r, 32'h8000_0000 | 32'(id));
                end
                wr(2'd2, 32'd0);
                e = e & ~low;
            end
            repeat (4) tick();
            rd(2'd1, r);
            checks++;
            if (intq !== 6'd0 || r !== 32'(v & ~m)) begin
                errors++; $display("FAIL rand_rest_t%0d: got intq %h pend %h expected 00 and %h", t, intq, r, v & ~m);
            end
            wr(2'd3, 32'd0);
            wr(2'd1, 32'h3F);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_priority();
        test_mask_drop();
        test_w1c_set();
        test_level();
        test_mid_reset();
        test_random_pending();
        test_random_priority();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
